// File: rtl/pps_capture_if.sv
// pps_capture_if -- signal bundle for the PPS capture block.
//   pps_in       : raw external PPS level, asynchronous to clk
//   pps_edge     : one-cycle pulse per detected rising edge
//   period       : clk cycles between the last two rising edges
//   period_valid : one-cycle pulse when period updates
//   width        : high time of the last pulse in clk cycles
//   width_valid  : one-cycle pulse when width updates
//   locked       : high while the tracker is locked
//   missing      : one-cycle pulse on a missing-pulse timeout
//   miss_count   : saturating count of timeouts
// master = PPS source / consumer side, slave = pps_capture.
interface pps_capture_if;
    logic        pps_in;
    logic        pps_edge;
    logic [31:0] period;
    logic        period_valid;
    logic [31:0] width;
    logic        width_valid;
    logic        locked;
    logic        missing;
    logic [15:0] miss_count;

    modport master (
        output pps_in,
        input  pps_edge, period, period_valid, width, width_valid,
               locked, missing, miss_count
    );

    modport slave (
        input  pps_in,
        output pps_edge, period, period_valid, width, width_valid,
               locked, missing, miss_count
    );
endinterface

// File: rtl/pps_capture.sv
// pps_capture -- measures period and high time of an external PPS signal
// and tracks lock against a nominal period.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : pps_capture_if.slave (pps_in in; edge/period/width/lock/miss out)
// Parameters: CLK_HZ nominal period in clk cycles, TOL_CYCLES allowed
// deviation either way, LOCK_COUNT consecutive good periods to lock,
// FILTER_LEN glitch-filter stability length.
// Build option: define PPS_CAPTURE_GLITCH_FILTER_EN to insert a glitch
// filter that accepts a new level only after FILTER_LEN stable cycles.
module pps_capture #(
    parameter int unsigned CLK_HZ     = 125000000,
    parameter int unsigned TOL_CYCLES = 1000,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    pps_capture_if.slave bus
);
    localparam int unsigned GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [32:0] HI = 33'(longint'(CLK_HZ) + longint'(TOL_CYCLES));
    localparam logic [32:0] LO = (CLK_HZ > TOL_CYCLES) ? 33'(CLK_HZ - TOL_CYCLES) : '0;
    // Cycles after reset before the level pipeline reflects real samples
    // of pps_in (with margin for the optional filter).
    localparam int unsigned PRIME_LAT = 6 + FILTER_LEN;
    localparam int unsigned PW = $clog2(PRIME_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] good_cnt, good_cnt_nx, good_inc;
    logic          s1, s2, filt, lvl, lvl_d;
    logic [PW-1:0] prime_cnt;
    logic          armed, seen_rise;
    logic          rise_ev, fall_ev, timeout, good;
    logic [31:0]   cnt, cnt_inc;
    logic [32:0]   period_calc;

    // Synchronizer, level/edge-detect registers and arming.
    // armed is set only once a real low level has been seen after reset,
    // so a pulse already in progress at reset is never taken as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            lvl       <= 1'b0;
            lvl_d     <= 1'b0;
            prime_cnt <= '0;
            armed     <= 1'b0;
            seen_rise <= 1'b0;
        end else begin
            s1    <= bus.pps_in;
            s2    <= s1;
            lvl   <= filt;
            lvl_d <= lvl;
            if (prime_cnt != PW'(PRIME_LAT))
                prime_cnt <= prime_cnt + 1'b1;
            if (prime_cnt == PW'(PRIME_LAT) && !lvl)
                armed <= 1'b1;
            if (rise_ev)
                seen_rise <= 1'b1;
        end
    end

`ifdef PPS_CAPTURE_GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] fcnt;

    // filt follows s2 only after s2 has differed from it for FILTER_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (s2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt <= s2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end
`else
    always_comb filt = s2;
`endif

    always_comb begin
        rise_ev     = lvl & ~lvl_d & armed;
        fall_ev     = ~lvl & lvl_d & seen_rise;
        cnt_inc     = (cnt == '1) ? cnt : cnt + 32'd1;
        period_calc = {1'b0, cnt} + 33'd1;
        good        = (period_calc >= LO) && (period_calc <= HI);
        good_inc    = good_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_cnt_nx;
        end
    end

    // An edge coinciding with the timeout point wins over the timeout.
    always_comb begin
        state_nx    = state;
        good_cnt_nx = good_cnt;
        timeout     = (state != IDLE) && ({1'b0, cnt} == HI) && !rise_ev;
        case (state)
            IDLE: begin
                if (rise_ev) begin
                    state_nx    = ACQUIRE;
                    good_cnt_nx = '0;
                end
            end
            ACQUIRE: begin
                if (rise_ev) begin
                    if (good) begin
                        good_cnt_nx = good_inc;
                        if (good_inc == GW'(LOCK_COUNT))
                            state_nx = LOCKED;
                    end else begin
                        good_cnt_nx = '0;
                    end
                end else if (timeout) begin
                    state_nx    = IDLE;
                    good_cnt_nx = '0;
                end
            end
            LOCKED: begin
                if (rise_ev) begin
                    if (!good) begin
                        state_nx    = ACQUIRE;
                        good_cnt_nx = '0;
                    end
                end else if (timeout) begin
                    state_nx    = IDLE;
                    good_cnt_nx = '0;
                end
            end
            default: begin
                state_nx    = IDLE;
                good_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt              <= '0;
            bus.pps_edge     <= 1'b0;
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
            bus.width        <= '0;
            bus.width_valid  <= 1'b0;
            bus.locked       <= 1'b0;
            bus.missing      <= 1'b0;
            bus.miss_count   <= '0;
        end else begin
            cnt              <= rise_ev ? '0 : cnt_inc;
            bus.pps_edge     <= rise_ev;
            bus.period_valid <= 1'b0;
            bus.width_valid  <= 1'b0;
            bus.missing      <= timeout;
            bus.locked       <= (state == LOCKED);
            if (rise_ev && state != IDLE) begin
                bus.period       <= cnt_inc;
                bus.period_valid <= 1'b1;
            end
            if (fall_ev) begin
                bus.width       <= cnt_inc;
                bus.width_valid <= 1'b1;
            end
            if (timeout && bus.miss_count != '1)
                bus.miss_count <= bus.miss_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_pps_capture.sv
// tb_pps_capture -- randomized scoreboard bench for pps_capture.
// Stimulus drives pps_in as (period, high) pulses; an abstract model of
// the tracking rules pushes expected edges, periods, widths and timeouts
// into queues which a negedge monitor pops as the DUT reports them.
`timescale 1ns/1ps
module tb_pps_capture;
    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned TOL    = 10;
    localparam int unsigned LOCKN  = 3;
    localparam int unsigned FLEN   = 4;
    localparam int unsigned LO     = CLK_HZ - TOL;
    localparam int unsigned HI     = CLK_HZ + TOL;
`ifdef PPS_CAPTURE_GLITCH_FILTER_EN
    localparam int unsigned LAT = 3 + FLEN;
`else
    localparam int unsigned LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    pps_capture_if bus ();

    pps_capture #(
        .CLK_HZ(CLK_HZ), .TOL_CYCLES(TOL), .LOCK_COUNT(LOCKN), .FILTER_LEN(FLEN)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        bit          has_period;
        int unsigned period;
        bit          locked_after;
    } edge_t;
    typedef struct {
        int unsigned cyc;
        int unsigned count;
    } miss_t;

    edge_t       edge_q[$];
    miss_t       miss_q[$];
    int unsigned width_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edges_seen = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: 0 idle, 1 acquiring, 2 locked.
    int          m_mode = 0;
    int unsigned m_good = 0;
    int unsigned m_miss = 0;
    bit          m_seen = 0;
    int unsigned m_last = 0;

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_miss = 0; m_seen = 0;
    endtask

    // A gap longer than HI+1 cycles since the last edge is a timeout.
    task automatic model_tick(input int unsigned now);
        miss_t m;
        if (m_mode != 0 && now - m_last == HI + 2) begin
            if (m_miss < 65535) m_miss++;
            m.cyc   = now + LAT;
            m.count = m_miss;
            miss_q.push_back(m);
            m_mode = 0;
        end
    endtask

    task automatic model_rise(input int unsigned now);
        edge_t e;
        int unsigned g;
        bit ok;
        e.cyc = now + 1 + LAT;
        e.has_period = 1'b0;
        e.period = 0;
        if (m_mode == 0) begin
            m_mode = 1;
            m_good = 0;
        end else begin
            g = now - m_last;
            ok = (g >= LO) && (g <= HI);
            e.has_period = 1'b1;
            e.period = g;
            if (m_mode == 1) begin
                if (ok) begin
                    m_good++;
                    if (m_good == LOCKN) m_mode = 2;
                end else begin
                    m_good = 0;
                end
            end else if (!ok) begin
                m_mode = 1;
                m_good = 0;
            end
        end
        e.locked_after = (m_mode == 2);
        edge_q.push_back(e);
        m_last = now;
        m_seen = 1'b1;
    endtask

    task automatic tick_wait(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            model_tick(cyc);
        end
    endtask

    task automatic pulse(input int unsigned period, input int unsigned high);
        bus.pps_in = 1'b1;
        model_rise(cyc);
        tick_wait(high);
        bus.pps_in = 1'b0;
        if (m_seen) width_q.push_back(high);
        tick_wait(period - high);
    endtask

    // Monitor
    bit chk_lock = 0;
    bit exp_lock = 0;
    always @(negedge clk) begin
        edge_t e;
        miss_t m;
        int unsigned w;
        if (!rst) begin
            if (chk_lock) begin
                check("locked", bus.locked == exp_lock, bus.locked, exp_lock);
                chk_lock = 0;
            end
            if (bus.pps_edge) begin
                edges_seen++;
                check("edge_expected", edge_q.size() != 0, 1, 0);
                if (edge_q.size() != 0) begin
                    e = edge_q.pop_front();
                    check("edge_cycle", cyc == e.cyc, cyc, e.cyc);
                    check("period_valid", bus.period_valid == e.has_period, bus.period_valid, e.has_period);
                    if (e.has_period)
                        check("period", bus.period == e.period, bus.period, e.period);
                    chk_lock = 1;
                    exp_lock = e.locked_after;
                end
            end else if (bus.period_valid) begin
                check("period_valid_without_edge", 1'b0, 1, 0);
            end
            if (bus.width_valid) begin
                check("width_expected", width_q.size() != 0, 1, 0);
                if (width_q.size() != 0) begin
                    w = width_q.pop_front();
                    check("width", bus.width == w, bus.width, w);
                end
            end
            if (bus.missing) begin
                check("missing_expected", miss_q.size() != 0, 1, 0);
                if (miss_q.size() != 0) begin
                    m = miss_q.pop_front();
                    check("missing_cycle", cyc == m.cyc, cyc, m.cyc);
                    check("miss_count", bus.miss_count == m.count, bus.miss_count, m.count);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        logic [31:0] mix;
        logic [4:0]  flags;
        mix   = bus.period | bus.width | 32'(bus.miss_count);
        flags = {bus.pps_edge, bus.period_valid, bus.width_valid, bus.locked, bus.missing};
        check({name, "_values"}, mix == '0, mix, 0);
        check({name, "_flags"}, flags == '0, flags, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected 0 pending", edge_q.size());
        $fatal(1);
    end

    initial begin
        int unsigned dir_p[] = '{1000, 1000, 1000, 1000, 1000, 1011, 1000, 1000, 1000,
                                 1010, 990, 989, 1000, 1000, 1000, 1000, 1200, 1000};
        int unsigned bnd[5];
        int unsigned p, h, r;
        bnd[0] = LO - 1; bnd[1] = LO; bnd[2] = HI; bnd[3] = HI + 1; bnd[4] = HI + 2;

        bus.pps_in = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("initial_reset");
        @(negedge clk);
        rst = 1'b0;
        tick_wait(20);

`ifdef PPS_CAPTURE_GLITCH_FILTER_EN
        bus.pps_in = 1'b1;
        tick_wait(3);
        bus.pps_in = 1'b0;
        tick_wait(40);
        check("glitch_rejected", edges_seen == 0, edges_seen, 0);
`endif

        // Directed: lock, late edge, relock, bounds, timeout and re-entry.
        foreach (dir_p[i]) pulse(dir_p[i], 100);

        // Randomized periods, weighted towards good edges.
        for (int unsigned n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      p = $urandom_range(LO, HI);
            else if (r == 6) p = $urandom_range(LO - 5, LO - 1);
            else if (r == 7) p = $urandom_range(HI + 1, HI + 1);
            else if (r == 8) p = $urandom_range(HI + 2, HI + 40);
            else             p = bnd[$urandom_range(0, 4)];
            h = $urandom_range(5, 200);
            pulse(p, h);
        end

        // Lock again, then reset in the middle of a pulse.
        repeat (4) pulse(1000, 100);
        bus.pps_in = 1'b1;
        model_rise(cyc);
        tick_wait(50);
        check("locked_before_reset", bus.locked == (m_mode == 2), bus.locked, m_mode == 2);
        rst = 1'b1;
        #1 check_reset_outputs("midpulse_reset");
        model_reset();
        chk_lock = 0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        tick_wait(30);
        bus.pps_in = 1'b0;
        tick_wait(900);
        pulse(1000, 100);
        pulse(1000, 100);
        tick_wait(20);

        check("edge_queue_drained", edge_q.size() == 0, edge_q.size(), 0);
        check("width_queue_drained", width_q.size() == 0, width_q.size(), 0);
        check("miss_queue_drained", miss_q.size() == 0, miss_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pps_capture.md
PPS_CAPTURE -- requirements
Module: pps_capture

Interface
REQ-001 Parameter CLK_HZ, default 125000000: nominal clk cycles per PPS period.
REQ-002 Parameter TOL_CYCLES, default 1000: allowed period deviation in cycles, applied in either direction.
REQ-003 Parameter LOCK_COUNT, default 3: consecutive good periods required to lock.
REQ-004 Parameter FILTER_LEN, default 4: glitch-filter stability length in cycles; used only when the filter is compiled in.
REQ-005 clk  in  1: system clock, rising-edge.
REQ-006 rst  in  1: reset, asynchronous, active-high.
REQ-007 pps_in  in  1: external PPS, asynchronous to clk.
REQ-008 pps_edge  out  1: one-cycle pulse per detected rising edge.
REQ-009 period  out  32: clk cycles between the last two rising edges.
REQ-010 period_valid  out  1: one-cycle pulse when period updates.
REQ-011 width  out  32: high time of the last pulse, in clk cycles.
REQ-012 width_valid  out  1: one-cycle pulse when width updates.
REQ-013 locked  out  1: high while in state LOCKED.
REQ-014 missing  out  1: one-cycle pulse on timeout.
REQ-015 miss_count  out  16: saturating count of timeouts.

Function
REQ-016 pps_in passes through a 2-flop synchronizer and then an edge-detect register; pps_edge asserts 3 clk cycles after the first clk edge that samples pps_in high (filter out).
REQ-017 Counter cnt (32-bit, saturating at 0xFFFFFFFF) clears to 0 in the pps_edge cycle and increments in every other cycle.
REQ-018 On pps_edge in ACQUIRE or LOCKED: period <= cnt+1 and period_valid pulses in the same cycle. On pps_edge in IDLE: period holds and period_valid stays low.
REQ-019 On a synchronized falling edge after a rising edge: width <= cnt+1 and width_valid pulses; falling edges with no prior rising edge since reset are ignored.
REQ-020 A period is good iff CLK_HZ-TOL_CYCLES <= period <= CLK_HZ+TOL_CYCLES; the comparison is unsigned, computed 33 bits wide.
REQ-021 States: IDLE, ACQUIRE, LOCKED; good_cnt is a counter wide enough to hold LOCK_COUNT.
REQ-022 IDLE: pps_edge -> ACQUIRE with good_cnt=0.
REQ-023 ACQUIRE: good edge increments good_cnt; when good_cnt reaches LOCK_COUNT -> LOCKED. Bad edge clears good_cnt and the state stays ACQUIRE.
REQ-024 LOCKED: good edge stays LOCKED; bad edge -> ACQUIRE with good_cnt=0.
REQ-025 Timeout: in ACQUIRE or LOCKED, when cnt == CLK_HZ+TOL_CYCLES with no edge that cycle -> missing pulses, miss_count increments (saturating at 0xFFFF), state -> IDLE. At most one timeout per gap.
REQ-026 When an edge and the timeout condition coincide, the edge wins: no timeout is recorded and the edge is evaluated as a period.
REQ-027 locked is registered from the state and deasserts in the cycle after the LOCKED exit transition.

Reset
REQ-028 rst clears all outputs, cnt, good_cnt, the synchronizer and the filter to 0, and sets the state to IDLE.
REQ-029 Reset mid-pulse: the first rising edge after reset is treated as the first edge, and no width is reported for the pulse in progress.

Configuration
REQ-030 Macro PPS_CAPTURE_GLITCH_FILTER_EN: when defined, the synchronized level is accepted only after it is stable for FILTER_LEN consecutive cycles, which adds FILTER_LEN cycles of latency to pps_edge and to falling-edge detection. When undefined, there is no filter, no added latency, and FILTER_LEN is unused.

Verification (CLK_HZ=1000, TOL_CYCLES=10, LOCK_COUNT=3, filter out unless noted)
REQ-031 Pulses every 1000 cycles, high 100 cycles -> period=1000 and width=100 each time; locked rises after the 4th edge; miss_count=0.
REQ-032 Locked, then one period of 1011 cycles -> period=1011, state ACQUIRE, locked=0; 3 further periods of 1000 -> locked=1.
REQ-033 Locked, then pps_in held low -> missing pulses when cnt reaches 1010, miss_count=1, state IDLE; the next edge gives period_valid=0.
REQ-034 Edges at 990 and 1010 cycles (both bounds) -> both good; 989 -> bad.
REQ-035 rst asserted mid-pulse while locked -> all outputs 0 immediately; after release, the first edge produces no period_valid.
REQ-036 Filter in (FILTER_LEN=4): 3-cycle high glitch -> no pps_edge; clean pulse -> pps_edge 4 cycles later than with the filter out.
